// File: rtl/axil_bram_bridge_pkg.sv
// Shared types for the AXI4-Lite to BRAM bridge: FSM state encoding and
// AXI response codes.
package axil_bram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_WAIT,
    RD_RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_bram_bridge_if.sv
// AXI4-Lite channel bundle; the bridge uses the slave modport, the
// requesting side the master modport.
interface axil_bram_bridge_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_rr_arb2.sv
// Two-way round-robin arbiter (write vs read). On contention the class not
// granted last wins; after reset write wins.
module axil_rr_arb2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req_wr,
  input  logic i_req_rd,
  output logic o_gnt_wr,
  output logic o_gnt_rd
);
  logic r_rd_prio;

  assign o_gnt_wr = i_req_wr & (~i_req_rd | ~r_rd_prio);
  assign o_gnt_rd = i_req_rd & (~i_req_wr |  r_rd_prio);

  // Requests are only presented when the grant is accepted, so any grant moves the pointer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_prio <= 1'b0;
    end else if (o_gnt_wr) begin
      r_rd_prio <= 1'b1;
    end else if (o_gnt_rd) begin
      r_rd_prio <= 1'b0;
    end
  end
endmodule

// File: rtl/axil_bram_bridge.sv
// AXI4-Lite slave to single-port BRAM bridge, one transaction in flight.
// Optional macro AXIL_BRAM_BRIDGE_ADDR_CHECK_EN: SLVERR on out-of-range addresses.
module axil_bram_bridge
  import axil_bram_pkg::*;
#(
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int AXI_ADDR_WIDTH    = 16,
  parameter int BRAM_ADDR_WIDTH   = 12,
  parameter int BRAM_READ_LATENCY = 1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  axil_bram_bridge_if.slave             s_axil,
  output logic [BRAM_ADDR_WIDTH-1:0]    bram_addr,
  output logic [AXI_DATA_WIDTH-1:0]     bram_wrdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   bram_we,
  output logic                          bram_en,
  input  logic [AXI_DATA_WIDTH-1:0]     bram_rddata
);
  localparam int         STRB_W = AXI_DATA_WIDTH / 8;
  localparam int         LSB    = $clog2(STRB_W);
  localparam int         HI     = BRAM_ADDR_WIDTH + LSB;
  localparam logic [1:0] LAT    = 2'(BRAM_READ_LATENCY);
`ifdef AXIL_BRAM_BRIDGE_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  if (AXI_DATA_WIDTH != 32 && AXI_DATA_WIDTH != 64) begin : g_bad_dw
    $error("AXI_DATA_WIDTH must be 32 or 64");
  end
  if (BRAM_READ_LATENCY < 1 || BRAM_READ_LATENCY > 3) begin : g_bad_lat
    $error("BRAM_READ_LATENCY must be in 1..3");
  end
  if (AXI_ADDR_WIDTH < HI) begin : g_bad_aw
    $error("AXI_ADDR_WIDTH too narrow for BRAM_ADDR_WIDTH");
  end

  state_e                      r_state, w_state_nx;
  logic                        r_armed;
  logic [1:0]                  r_cnt, w_cnt_nx;
  logic [BRAM_ADDR_WIDTH-1:0]  r_addr;
  logic [AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_W-1:0]           r_strb;
  logic                        r_ok;
  logic [AXI_DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]                  r_bresp, r_rresp;

  logic                        w_accept, w_wr_go, w_rd_go;
  logic                        w_aw_ok, w_ar_ok;
  logic                        w_bram_en;
  logic [STRB_W-1:0]           w_bram_we;

  // Requests are only visible to the arbiter in IDLE, and never in the first cycle out of reset
  assign w_accept = (r_state == IDLE) && r_armed;

  axil_rr_arb2 u_arb (
    .i_clk    (aclk),
    .i_rst_n  (aresetn),
    .i_req_wr (w_accept & s_axil.awvalid & s_axil.wvalid),
    .i_req_rd (w_accept & s_axil.arvalid),
    .o_gnt_wr (w_wr_go),
    .o_gnt_rd (w_rd_go)
  );

  assign w_aw_ok = !ADDR_CHECK || ((s_axil.awaddr >> HI) == '0);
  assign w_ar_ok = !ADDR_CHECK || ((s_axil.araddr >> HI) == '0);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
      r_armed <= 1'b0;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nx;
      r_armed <= 1'b1;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_bram_en  = 1'b0;
    w_bram_we  = '0;
    case (r_state)
      IDLE: begin
        if (w_wr_go) begin
          w_state_nx = WR;
        end else if (w_rd_go) begin
          w_state_nx = RD_WAIT;
          w_cnt_nx   = LAT;
        end
      end
      WR: begin
        w_state_nx = WR_RESP;
        w_bram_en  = r_ok;
        w_bram_we  = r_ok ? r_strb : '0;
      end
      WR_RESP: begin
        if (s_axil.bready) w_state_nx = IDLE;
      end
      RD_WAIT: begin
        // Enable only on the first wait cycle; the counter then covers the BRAM pipeline
        w_bram_en = r_ok && (r_cnt == LAT);
        if (r_cnt == 2'd0) w_state_nx = RD_RESP;
        else               w_cnt_nx   = r_cnt - 2'd1;
      end
      RD_RESP: begin
        if (s_axil.rready) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_ok    <= 1'b0;
      r_bresp <= RESP_OKAY;
      r_rresp <= RESP_OKAY;
      r_rdata <= '0;
    end else begin
      if (w_wr_go) begin
        r_addr  <= s_axil.awaddr[HI-1:LSB];
        r_wdata <= s_axil.wdata;
        r_strb  <= s_axil.wstrb;
        r_ok    <= w_aw_ok;
        r_bresp <= w_aw_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (w_rd_go) begin
        r_addr  <= s_axil.araddr[HI-1:LSB];
        r_ok    <= w_ar_ok;
        r_rresp <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
      end
      if (r_state == RD_WAIT && r_cnt == 2'd0) begin
        r_rdata <= r_ok ? bram_rddata : '0;
      end
    end
  end

  assign s_axil.awready = w_wr_go;
  assign s_axil.wready  = w_wr_go;
  assign s_axil.arready = w_rd_go;
  assign s_axil.bvalid  = (r_state == WR_RESP);
  assign s_axil.bresp   = r_bresp;
  assign s_axil.rvalid  = (r_state == RD_RESP);
  assign s_axil.rresp   = r_rresp;
  assign s_axil.rdata   = r_rdata;

  assign bram_addr   = r_addr;
  assign bram_wrdata = r_wdata;
  assign bram_en     = w_bram_en;
  assign bram_we     = w_bram_we;
endmodule

// File: tb/tb_axil_bram_bridge.sv
// Directed bench for axil_bram_bridge with a 3-cycle-latency BRAM model.
module tb_axil_bram_bridge;
  import axil_bram_pkg::*;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int BAW = 12;
  localparam int LAT = 3;

  logic            aclk;
  logic            aresetn;
  logic [BAW-1:0]  bram_addr;
  logic [DW-1:0]   bram_wrdata;
  logic [DW-1:0]   bram_rddata;
  logic [DW/8-1:0] bram_we;
  logic            bram_en;

  int n_chk = 0;
  int n_bad = 0;
  int en_cnt = 0;
  int rv_cnt = 0;

  logic [DW-1:0] mem  [0:(1<<BAW)-1];
  logic [DW-1:0] pipe [0:LAT-1];

  axil_bram_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) s_axil ();

  axil_bram_bridge #(
    .AXI_DATA_WIDTH    (DW),
    .AXI_ADDR_WIDTH    (AW),
    .BRAM_ADDR_WIDTH   (BAW),
    .BRAM_READ_LATENCY (LAT)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_axil      (s_axil),
    .bram_addr   (bram_addr),
    .bram_wrdata (bram_wrdata),
    .bram_we     (bram_we),
    .bram_en     (bram_en),
    .bram_rddata (bram_rddata)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (bram_en) begin
      for (int b = 0; b < DW/8; b++)
        if (bram_we[b]) mem[bram_addr][b*8 +: 8] <= bram_wrdata[b*8 +: 8];
      pipe[0] <= mem[bram_addr];
    end
    for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
  end
  assign bram_rddata = pipe[LAT-1];

  always @(negedge aclk) begin
    if (bram_en)       en_cnt <= en_cnt + 1;
    if (s_axil.rvalid) rv_cnt <= rv_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_awready"}, s_axil.awready, 0);
    check({pfx, "_arready"}, s_axil.arready, 0);
    check({pfx, "_bvalid"},  s_axil.bvalid,  0);
    check({pfx, "_rvalid"},  s_axil.rvalid,  0);
    check({pfx, "_en"},      bram_en,        0);
    check({pfx, "_we"},      bram_we,        0);
    check({pfx, "_addr"},    bram_addr,      0);
    check({pfx, "_rdata"},   s_axil.rdata,   0);
  endtask

  task automatic axi_wr(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [DW/8-1:0] strb, input logic [BAW-1:0] exp_addr,
                        input logic exp_en, input logic [1:0] exp_resp);
    int n;
    int en0;
    bit hs;
    @(posedge aclk); #1;
    s_axil.awaddr = addr; s_axil.wdata = data; s_axil.wstrb = strb;
    s_axil.awvalid = 1'b1; s_axil.wvalid = 1'b1;
    hs = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge aclk);
      if (s_axil.awready) begin hs = 1'b1; break; end
    end
    check("wr_hs", hs, 1);
    check("wr_wready", s_axil.wready, 1);
    en0 = en_cnt;
    @(posedge aclk); #1;
    s_axil.awvalid = 1'b0; s_axil.wvalid = 1'b0;
    n = 0; hs = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge aclk);
      n++;
      if (n == 1) begin
        check("wr_we", bram_we, exp_en ? strb : '0);
        if (exp_en) begin
          check("wr_addr", bram_addr, exp_addr);
          check("wr_data", bram_wrdata, data);
        end
      end
      if (s_axil.bvalid) begin hs = 1'b1; break; end
    end
    check("wr_bvalid_seen", hs, 1);
    check("wr_latency", n, 2);
    check("wr_bresp", s_axil.bresp, exp_resp);
    check("wr_en_cycles", en_cnt - en0, exp_en);
    @(negedge aclk);
    check("wr_bvalid_hold", s_axil.bvalid, 1);
    s_axil.bready = 1'b1;
    @(posedge aclk); #1;
    s_axil.bready = 1'b0;
    @(negedge aclk);
    check("wr_bvalid_drop", s_axil.bvalid, 0);
  endtask

  task automatic axi_rd(input logic [AW-1:0] addr, input logic [DW-1:0] exp_data,
                        input logic [BAW-1:0] exp_addr, input logic exp_en,
                        input logic [1:0] exp_resp, input int hold);
    int n;
    int en0;
    bit hs;
    @(posedge aclk); #1;
    s_axil.araddr = addr; s_axil.arvalid = 1'b1;
    hs = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge aclk);
      if (s_axil.arready) begin hs = 1'b1; break; end
    end
    check("rd_hs", hs, 1);
    en0 = en_cnt;
    @(posedge aclk); #1;
    s_axil.arvalid = 1'b0;
    n = 0; hs = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge aclk);
      n++;
      if (n == 1) begin
        check("rd_en", bram_en, exp_en);
        check("rd_we", bram_we, 0);
        if (exp_en) check("rd_addr", bram_addr, exp_addr);
      end
      if (s_axil.rvalid) begin hs = 1'b1; break; end
    end
    check("rd_rvalid_seen", hs, 1);
    check("rd_latency", n, LAT + 2);
    check("rd_data", s_axil.rdata, exp_data);
    check("rd_rresp", s_axil.rresp, exp_resp);
    check("rd_en_cycles", en_cnt - en0, exp_en);
    for (int k = 0; k < hold; k++) begin
      @(negedge aclk);
      check("rd_rvalid_hold", s_axil.rvalid, 1);
      check("rd_data_hold", s_axil.rdata, exp_data);
    end
    s_axil.rready = 1'b1;
    @(posedge aclk); #1;
    s_axil.rready = 1'b0;
    @(negedge aclk);
    check("rd_rvalid_drop", s_axil.rvalid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    string   seq;
    string   exp_seq;
    int      g;
    int      rv0;
    aresetn = 1'b0;
    s_axil.awaddr = 16'h0100; s_axil.wdata = 32'h0123_4567; s_axil.wstrb = 4'hF;
    s_axil.araddr = 16'h0100;
    s_axil.awvalid = 1'b1; s_axil.wvalid = 1'b1; s_axil.arvalid = 1'b1;
    s_axil.bready = 1'b1; s_axil.rready = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_quiet("rst");
    check("rst_wready", s_axil.wready, 0);

    // Release with all requests pending: first cycle accepts nothing, then W,R,W,R
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("rel_awready", s_axil.awready, 0);
    check("rel_arready", s_axil.arready, 0);
    seq = ""; exp_seq = "WRWR"; g = 0;
    for (int k = 0; k < 80 && g < 4; k++) begin
      @(negedge aclk);
      if (s_axil.awready) begin
        check("rr_wready_pair", s_axil.wready, 1);
        seq = {seq, "W"}; g++;
      end else if (s_axil.arready) begin
        seq = {seq, "R"}; g++;
      end
    end
    @(posedge aclk); #1;
    s_axil.awvalid = 1'b0; s_axil.wvalid = 1'b0; s_axil.arvalid = 1'b0;
    check("rr_count", g, 4);
    for (int i = 0; i < 4; i++) check("rr_grant", (i < seq.len()) ? seq[i] : 8'h3F, exp_seq[i]);
    repeat (12) @(posedge aclk);
    s_axil.bready = 1'b0; s_axil.rready = 1'b0;

    axi_wr(16'h0010, 32'hDEAD_BEEF, 4'hF, 12'd4, 1'b1, RESP_OKAY);
    axi_rd(16'h0010, 32'hDEAD_BEEF, 12'd4, 1'b1, RESP_OKAY, 4);

    axi_wr(16'h0020, 32'h1122_3344, 4'hF, 12'd8, 1'b1, RESP_OKAY);
    axi_wr(16'h0020, 32'h0000_AB00, 4'h2, 12'd8, 1'b1, RESP_OKAY);
    axi_rd(16'h0020, 32'h1122_AB44, 12'd8, 1'b1, RESP_OKAY, 0);

    axi_wr(16'h0033, 32'hCAFE_F00D, 4'hF, 12'd12, 1'b1, RESP_OKAY);
    axi_rd(16'h0031, 32'hCAFE_F00D, 12'd12, 1'b1, RESP_OKAY, 1);

    axi_rd(16'h0100, 32'h0123_4567, 12'h040, 1'b1, RESP_OKAY, 0);

`ifdef AXIL_BRAM_BRIDGE_ADDR_CHECK_EN
    axi_rd(16'h8000, 32'h0, 12'd0, 1'b0, RESP_SLVERR, 0);
    axi_rd(16'h8010, 32'h0, 12'd4, 1'b0, RESP_SLVERR, 0);
    axi_wr(16'h8020, 32'h5555_5555, 4'hF, 12'd8, 1'b0, RESP_SLVERR);
    axi_rd(16'h0020, 32'h1122_AB44, 12'd8, 1'b1, RESP_OKAY, 0);
`else
    axi_rd(16'h8010, 32'hDEAD_BEEF, 12'd4, 1'b1, RESP_OKAY, 0);
    axi_wr(16'h8020, 32'h5555_5555, 4'hF, 12'd8, 1'b1, RESP_OKAY);
    axi_rd(16'h0020, 32'h5555_5555, 12'd8, 1'b1, RESP_OKAY, 0);
`endif

    // Reset while waiting on the BRAM: no response may escape
    @(posedge aclk); #1;
    s_axil.araddr = 16'h0010; s_axil.arvalid = 1'b1;
    g = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge aclk);
      if (s_axil.arready) begin g = 1; break; end
    end
    check("mid_hs", g, 1);
    @(posedge aclk); #1;
    s_axil.arvalid = 1'b0;
    @(posedge aclk); #1;
    rv0 = rv_cnt;
    aresetn = 1'b0;
    #1;
    check_quiet("mid_rst");
    @(posedge aclk); #1;
    aresetn = 1'b1;
    repeat (10) @(posedge aclk);
    check("mid_no_rvalid", rv_cnt - rv0, 0);
    axi_rd(16'h0010, 32'hDEAD_BEEF, 12'd4, 1'b1, RESP_OKAY, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
